// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Pipeline stage register with a valid/ready handshake and a 2-entry skid
//   buffer (head + skid). It supports back-pressure without losing data, a
//   synchronous flush that inserts a bubble, and saturating counters for
//   squashed entries and bubble cycles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. Once out_valid is high, out_data and out_valid stay stable until
//   out_ready is sampled high. in_ready depends only on the registered state,
//   flush and reset. There is no combinational path from in_valid or out_ready
//   to any output.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream has a payload on in_data
//   in_ready   the stage accepts in_data this cycle
//   in_data    upstream payload [WIDTH]
//   out_valid  out_data is a valid entry
//   out_ready  downstream consumes out_data this cycle
//   out_data   head entry payload [WIDTH]
//   squash_cnt valid entries discarded by flush, saturating [CNT_W]
//   bubble_cnt cycles with out_ready=1 and out_valid=0, saturating [CNT_W]
//   fsm_state  debug view of the state: 0=EMPTY, 1=BUSY, 2=FULL
module pipe_stage_skid #(
  parameter int WIDTH         = 207,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] squash_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] head, skid;
  logic             in_fire, out_fire;
  logic             head_ld, head_from_skid, skid_ld;
  logic [1:0]       squash_inc;
  logic             bubble_inc;

  // The increment is widened by one bit so that a carry out of the counter
  // width signals saturation. This also covers a +2 step from all-ones-1.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) sat_add = '1;
    else            sat_add = sum[CNT_W-1:0];
  endfunction

  assign out_valid  = (state != EMPTY);
  assign in_ready   = (state != FULL) & ~flush & ~reset;
  assign out_data   = head;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign bubble_inc = out_ready & ~out_valid;
  assign fsm_state  = state;

  always_comb begin
    state_nx       = state;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    squash_inc     = 2'd0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nx = BUSY;
          head_ld  = 1'b1;
        end
      end
      BUSY: begin
        // A head that is delivered in the flush cycle is not counted as squashed.
        squash_inc = out_fire ? 2'd0 : 2'd1;
        if (in_fire && out_fire) begin
          head_ld = 1'b1;
        end else if (in_fire) begin
          state_nx = FULL;
          skid_ld  = 1'b1;
        end else if (out_fire) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        squash_inc = out_fire ? 2'd1 : 2'd2;
        if (out_fire) begin
          state_nx       = BUSY;
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // in_ready is low during flush, so no entry is accepted in this cycle.
    if (flush) state_nx = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      squash_cnt <= '0;
      bubble_cnt <= '0;
      if (ZERO_ON_FLUSH) begin
        head <= '0;
        skid <= '0;
      end
    end else begin
      state <= state_nx;
      if (bubble_inc) bubble_cnt <= sat_add(bubble_cnt, 2'd1);
      if (flush) begin
        squash_cnt <= sat_add(squash_cnt, squash_inc);
        if (ZERO_ON_FLUSH) begin
          head <= '0;
          skid <= '0;
        end
      end else begin
        if (head_ld) head <= head_from_skid ? skid : in_data;
        if (skid_ld) skid <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int W = 16;
  localparam int CW = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] squash_cnt, bubble_cnt;
  logic [1:0]    fsm_state;

  pipe_stage_skid #(.WIDTH(W), .ZERO_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .squash_cnt(squash_cnt), .bubble_cnt(bubble_cnt), .fsm_state(fsm_state)
  );

  // small-counter instance for saturation checks
  logic         s_reset, s_flush, s_in_valid, s_out_ready;
  logic [W-1:0] s_in_data;
  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_squash_cnt, s_bubble_cnt, s_fsm_state;

  pipe_stage_skid #(.WIDTH(W), .ZERO_ON_FLUSH(1'b1), .CNT_W(2)) dut_s (
    .clk(clk), .reset(s_reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .squash_cnt(s_squash_cnt), .bubble_cnt(s_bubble_cnt), .fsm_state(s_fsm_state)
  );

  // scoreboard / reference model
  logic [W-1:0] exp_q[$];
  int  m_sq, m_bb;
  bit  m_zero;
  int  n_pass, n_total;
  localparam int CMAX = (1 << CW) - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Applies one cycle of inputs. Outputs are compared at the falling edge
  // against the model, and against the optional hand-derived table values
  // (-1 means skip). The model then advances at the rising edge.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                      input logic fl, input logic rst,
                      input int e_ir, input int e_ov, input int e_sq, input int e_bb);
    bit m_ir, m_ov, ofire, ifire;
    int  sz;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; reset = rst;
    @(negedge clk);
    sz   = exp_q.size();
    m_ov = (sz > 0);
    m_ir = (sz < 2) && !fl && !rst;
    chk("in_ready", in_ready, m_ir);
    chk("out_valid", out_valid, m_ov);
    chk("state", fsm_state, sz);
    if (m_ov)        chk("out_data", out_data, exp_q[0]);
    else if (m_zero) chk("zero_payload", out_data, 0);
    chk("squash_cnt", squash_cnt, m_sq);
    chk("bubble_cnt", bubble_cnt, m_bb);
    if (e_ir >= 0) chk("tbl_in_ready", in_ready, e_ir);
    if (e_ov >= 0) chk("tbl_out_valid", out_valid, e_ov);
    if (e_sq >= 0) chk("tbl_squash", squash_cnt, e_sq);
    if (e_bb >= 0) chk("tbl_bubble", bubble_cnt, e_bb);
    @(posedge clk);
    ofire = m_ov && ordy;
    ifire = iv && m_ir;
    if (rst) begin
      exp_q.delete(); m_sq = 0; m_bb = 0; m_zero = 1'b1;
    end else begin
      if (ordy && !m_ov) m_bb = (m_bb >= CMAX) ? CMAX : m_bb + 1;
      if (fl) begin
        m_sq = m_sq + sz - (ofire ? 1 : 0);
        if (m_sq > CMAX) m_sq = CMAX;
        exp_q.delete();
        m_zero = 1'b1;
      end else begin
        if (ofire) void'(exp_q.pop_front());
        if (ifire) begin exp_q.push_back(d); m_zero = 1'b0; end
      end
    end
    #1;
  endtask

  typedef struct {
    logic iv; logic [W-1:0] d; logic ordy; logic fl; logic rst;
    int e_ir; int e_ov; int e_sq; int e_bb;
  } vec_t;

  vec_t tbl[30];

  initial begin
    n_pass = 0; n_total = 0; m_sq = 0; m_bb = 0; m_zero = 1'b1;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_reset = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;

    // {iv, d, ordy, fl, rst, exp in_ready, exp out_valid, exp squash, exp bubble}
    tbl[0]  = '{0, 16'h0,  1, 0, 0, 1, 0, 0, 0};   // idle bubbles
    tbl[1]  = '{0, 16'h0,  1, 0, 0, 1, 0, -1, 1};
    tbl[2]  = '{0, 16'h0,  1, 0, 0, 1, 0, -1, 2};
    tbl[3]  = '{1, 16'h1,  1, 0, 0, 1, 0, -1, 3};  // streaming 1..4
    tbl[4]  = '{1, 16'h2,  1, 0, 0, 1, 1, -1, 4};
    tbl[5]  = '{1, 16'h3,  1, 0, 0, 1, 1, -1, -1};
    tbl[6]  = '{1, 16'h4,  1, 0, 0, 1, 1, -1, -1};
    tbl[7]  = '{0, 16'h0,  1, 0, 0, 1, 1, -1, -1};
    tbl[8]  = '{1, 16'hA,  0, 0, 0, 1, 0, -1, 4};  // back-pressure
    tbl[9]  = '{1, 16'hB,  0, 0, 0, 1, 1, -1, -1};
    tbl[10] = '{1, 16'hC,  0, 0, 0, 0, 1, -1, -1}; // FULL: C refused
    tbl[11] = '{0, 16'h0,  0, 0, 0, 0, 1, -1, -1};
    tbl[12] = '{0, 16'h0,  1, 0, 0, 0, 1, -1, -1}; // A out
    tbl[13] = '{0, 16'h0,  1, 0, 0, 1, 1, -1, -1}; // B out
    tbl[14] = '{1, 16'h5,  0, 0, 0, 1, 0, -1, -1}; // flush in FULL
    tbl[15] = '{1, 16'h6,  0, 0, 0, 1, 1, -1, -1};
    tbl[16] = '{1, 16'h7,  0, 1, 0, 0, 1, 0, -1};
    tbl[17] = '{0, 16'h0,  0, 0, 0, 1, 0, 2, -1};
    tbl[18] = '{1, 16'h8,  0, 0, 0, 1, 0, -1, -1}; // flush + out_fire in BUSY
    tbl[19] = '{0, 16'h0,  1, 1, 0, 0, 1, 2, -1};
    tbl[20] = '{0, 16'h0,  0, 0, 0, 1, 0, 2, -1};
    tbl[21] = '{1, 16'h9,  0, 0, 0, 1, 0, -1, -1}; // flush + out_fire in FULL
    tbl[22] = '{1, 16'h10, 0, 0, 0, 1, 1, -1, -1};
    tbl[23] = '{0, 16'h0,  1, 1, 0, 0, 1, 2, -1};
    tbl[24] = '{1, 16'h11, 0, 0, 0, 1, 0, 3, -1}; // flush in BUSY
    tbl[25] = '{0, 16'h0,  0, 1, 0, 0, 1, 3, -1};
    tbl[26] = '{1, 16'h12, 0, 0, 0, 1, 0, 4, 4};  // reset (with flush) while FULL
    tbl[27] = '{1, 16'h13, 0, 0, 0, 1, 1, -1, -1};
    tbl[28] = '{0, 16'h0,  1, 1, 1, 0, 1, -1, -1};
    tbl[29] = '{0, 16'h0,  0, 0, 0, 1, 0, 0, 0};

    // reset, then check the reset state while reset is still held
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_squash", squash_cnt, 0);
    chk("rst_bubble", bubble_cnt, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++)
      step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].rst,
           tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_sq, tbl[i].e_bb);

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), W'($urandom_range(0, 65535)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 199) == 0), -1, -1, -1, -1);
    step(0, '0, 1, 0, 0, -1, -1, -1, -1);

    // saturation on the CNT_W=2 instance
    @(posedge clk); #1;
    s_reset = 1'b0; s_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_bubble", s_bubble_cnt, 3);
    chk("sat_in_ready", s_in_ready, 1);
    s_out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      s_in_valid = 1'b1; s_in_data = W'(16'h50 + r);
      repeat (2) @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      @(negedge clk);
      chk("sat_full_state", s_fsm_state, 2);
      s_flush = 1'b1;
      @(posedge clk); #1;
      s_flush = 1'b0;
      @(negedge clk);
      chk("sat_squash", s_squash_cnt, (r == 0) ? 2 : 3);
      chk("sat_zero_payload", s_out_data, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
